dm_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the Data_Memory block. It shares the single memory port between the CPU load/store path (port 0) and the DMA/IO path (port 1). It drives the memory's address, write, and read controls from registers, and routes the registered read data back to the requester that issued the read. Data_Memory's Write_clock and Read_clock are both tied to this block's Clock.

---
 rtl/dm_arbiter_pkg.sv | 12 +
 rtl/dm_arbiter_if.sv | 50 +++++
 rtl/dm_arb_pick.sv | 33 +++
 rtl/dm_arbiter.sv | 117 +++++++++++
 tb/tb_dm_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared CPU-side types and widths used by the data-memory arbiter.
package CPU_package;

   localparam int ADDRESS_WIDTH = 8;
   localparam int DATA_WIDTH    = 16;

   // State records which port, if any, was granted at the last edge.
   typedef enum logic [1:0] {ARB_IDLE, ARB_G0, ARB_G1} arb_state_t;

   localparam int ARB_PORTS = 2;

endpackage

// File: rtl/dm_arbiter_if.sv
// Request/response bus between the two requesters, dm_arbiter and Data_Memory.
interface dm_arbiter_if
   import CPU_package::*;
#(
   parameter int ADDR_W = ADDRESS_WIDTH,
   parameter int DATA_W = DATA_WIDTH
);

   logic              P0_Req;
   logic              P0_Write;
   logic [ADDR_W-1:0] P0_Address;
   logic [DATA_W-1:0] P0_Wdata;
   logic              P0_Ack;
   logic              P0_Rvalid;
   logic [DATA_W-1:0] P0_Rdata;

   logic              P1_Req;
   logic              P1_Write;
   logic [ADDR_W-1:0] P1_Address;
   logic [DATA_W-1:0] P1_Wdata;
   logic              P1_Ack;
   logic              P1_Rvalid;
   logic [DATA_W-1:0] P1_Rdata;

   logic [ADDR_W-1:0] Mem_Address;
   logic              Mem_Write_Enable;
   logic [DATA_W-1:0] Mem_Wdata;
   logic              Mem_Read_Enable;
   logic [DATA_W-1:0] Mem_Rdata;

   // The arbiter side sees requests and memory read data as inputs.
   modport slave (
      input  P0_Req, P0_Write, P0_Address, P0_Wdata,
      input  P1_Req, P1_Write, P1_Address, P1_Wdata,
      input  Mem_Rdata,
      output P0_Ack, P0_Rvalid, P0_Rdata,
      output P1_Ack, P1_Rvalid, P1_Rdata,
      output Mem_Address, Mem_Write_Enable, Mem_Wdata, Mem_Read_Enable
   );

   modport master (
      output P0_Req, P0_Write, P0_Address, P0_Wdata,
      output P1_Req, P1_Write, P1_Address, P1_Wdata,
      output Mem_Rdata,
      input  P0_Ack, P0_Rvalid, P0_Rdata,
      input  P1_Ack, P1_Rvalid, P1_Rdata,
      input  Mem_Address, Mem_Write_Enable, Mem_Wdata, Mem_Read_Enable
   );

endinterface

// File: rtl/dm_arb_pick.sv
// Combinational 2-way grant picker; round-robin when DM_ARB_RR_EN is defined,
// otherwise fixed priority to port 0.
module dm_arb_pick
   import CPU_package::*;
(
   input  logic [ARB_PORTS-1:0] req,
   input  logic [ARB_PORTS-1:0] busy,
`ifdef DM_ARB_RR_EN
   input  logic                 ptr,
`endif
   output logic [ARB_PORTS-1:0] grant
);

   logic [ARB_PORTS-1:0] elig;

   assign elig = req & ~busy;

   // A port granted at the last edge is masked so a held request is not served twice.
   always_comb begin
      grant = '0;
`ifdef DM_ARB_RR_EN
      if (elig == 2'b11) begin
         grant = ptr ? 2'b10 : 2'b01;
      end else begin
         grant = elig;
      end
`else
      grant[0] = elig[0];
      grant[1] = elig[1] & ~elig[0];
`endif
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of Data_Memory with registered memory controls
// and read-data routing. Optional round-robin arbitration via DM_ARB_RR_EN.
module dm_arbiter
   import CPU_package::*;
#(
   parameter int ADDR_W = ADDRESS_WIDTH,
   parameter int DATA_W = DATA_WIDTH
) (
   input  logic        Clock,
   input  logic        Reset_n,
   dm_arbiter_if.slave bus
);

   arb_state_t           state_q;
   arb_state_t           state_d;
   logic [ARB_PORTS-1:0] busy;
   logic [ARB_PORTS-1:0] grant;

   logic                 sel_write;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;

   logic [ADDR_W-1:0]    mem_addr_q;
   logic [DATA_W-1:0]    mem_wdata_q;
   logic                 mem_we_q;
   logic                 mem_re_q;
   logic                 owner_q;
   logic                 rvalid_pend_q;
   logic                 p0_rvalid_q;
   logic                 p1_rvalid_q;

`ifdef DM_ARB_RR_EN
   logic                 rr_ptr_q;
`endif

   assign busy = {state_q == ARB_G1, state_q == ARB_G0};

   dm_arb_pick u_pick (
      .req   ({bus.P1_Req, bus.P0_Req}),
      .busy  (busy),
`ifdef DM_ARB_RR_EN
      .ptr   (rr_ptr_q),
`endif
      .grant (grant)
   );

   // Next grant state and the request fields to be launched toward memory.
   always_comb begin
      state_d   = ARB_IDLE;
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (grant[0]) begin
         state_d   = ARB_G0;
         sel_write = bus.P0_Write;
         sel_addr  = bus.P0_Address;
         sel_wdata = bus.P0_Wdata;
      end else if (grant[1]) begin
         state_d   = ARB_G1;
         sel_write = bus.P1_Write;
         sel_addr  = bus.P1_Address;
         sel_wdata = bus.P1_Wdata;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q       <= ARB_IDLE;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_we_q      <= 1'b0;
         mem_re_q      <= 1'b0;
         owner_q       <= 1'b0;
         rvalid_pend_q <= 1'b0;
         p0_rvalid_q   <= 1'b0;
         p1_rvalid_q   <= 1'b0;
`ifdef DM_ARB_RR_EN
         rr_ptr_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (state_d != ARB_IDLE) begin
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_write;
            mem_re_q    <= ~sel_write;
         end else begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
         end
         if ((state_d != ARB_IDLE) && !sel_write) begin
            owner_q <= grant[1];
         end
         // Owner is still the old value here, so back-to-back reads route correctly.
         rvalid_pend_q <= (state_d != ARB_IDLE) && !sel_write;
         p0_rvalid_q   <= rvalid_pend_q && !owner_q;
         p1_rvalid_q   <= rvalid_pend_q && owner_q;
`ifdef DM_ARB_RR_EN
         if (grant != '0) begin
            rr_ptr_q <= grant[0];
         end
`endif
      end
   end

   assign bus.P0_Ack           = (state_q == ARB_G0);
   assign bus.P1_Ack           = (state_q == ARB_G1);
   assign bus.P0_Rvalid        = p0_rvalid_q;
   assign bus.P1_Rvalid        = p1_rvalid_q;
   assign bus.P0_Rdata         = bus.Mem_Rdata;
   assign bus.P1_Rdata         = bus.Mem_Rdata;
   assign bus.Mem_Address      = mem_addr_q;
   assign bus.Mem_Wdata        = mem_wdata_q;
   assign bus.Mem_Write_Enable = mem_we_q;
   assign bus.Mem_Read_Enable  = mem_re_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a registered-read Data_Memory model.
module tb_dm_arbiter;
   import CPU_package::*;

   typedef struct {
      int          port;
      logic [15:0] data;
   } rd_exp_t;

   logic        Clock;
   logic        Reset_n;
   logic [15:0] mem [0:255];
   logic [15:0] mem_rdata;
   int          checks;
   int          failures;
   int          ack_q [$];
   rd_exp_t     rd_q [$];
   logic        prev_p0_ack;

   dm_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

   dm_arbiter dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus.slave)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Data_Memory stand-in: write and registered read on the same clock.
   always @(posedge Clock) begin
      if (bus.Mem_Write_Enable) mem[bus.Mem_Address] <= bus.Mem_Wdata;
      if (bus.Mem_Read_Enable) mem_rdata <= mem[bus.Mem_Address];
   end
   assign bus.Mem_Rdata = mem_rdata;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int port, input logic wr, input logic [7:0] addr, input logic [15:0] data);
      if (port == 0) begin
         bus.P0_Req = 1'b1; bus.P0_Write = wr; bus.P0_Address = addr; bus.P0_Wdata = data;
      end else begin
         bus.P1_Req = 1'b1; bus.P1_Write = wr; bus.P1_Address = addr; bus.P1_Wdata = data;
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic resetPulse();
      Reset_n = 1'b0;
      #3;
      step();
      Reset_n = 1'b1;
   endtask

   task automatic pushRead(input int port, input logic [15:0] data);
      rd_exp_t e;
      e.port = port;
      e.data = data;
      rd_q.push_back(e);
   endtask

   // Monitor: every Ack and Rvalid the DUT presents is matched against the queues.
   always @(negedge Clock) begin
      if (bus.P0_Ack) begin
         checkOutput("p0_no_consecutive_ack", {31'd0, prev_p0_ack}, 32'd0);
         if (ack_q.size() == 0) checkOutput("unexpected_ack_port", 32'd0, 32'hFFFF_FFFF);
         else checkOutput("ack_port", 32'd0, ack_q.pop_front());
      end
      if (bus.P1_Ack) begin
         if (ack_q.size() == 0) checkOutput("unexpected_ack_port", 32'd1, 32'hFFFF_FFFF);
         else checkOutput("ack_port", 32'd1, ack_q.pop_front());
      end
      if (bus.P0_Rvalid) begin
         if (rd_q.size() == 0) checkOutput("unexpected_rvalid_port", 32'd0, 32'hFFFF_FFFF);
         else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            checkOutput("rvalid_port", 32'd0, e.port);
            checkOutput("p0_rdata", {16'd0, bus.P0_Rdata}, {16'd0, e.data});
         end
      end
      if (bus.P1_Rvalid) begin
         if (rd_q.size() == 0) checkOutput("unexpected_rvalid_port", 32'd1, 32'hFFFF_FFFF);
         else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            checkOutput("rvalid_port", 32'd1, e.port);
            checkOutput("p1_rdata", {16'd0, bus.P1_Rdata}, {16'd0, e.data});
         end
      end
      prev_p0_ack = bus.P0_Ack;
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_p0_ack"}, {31'd0, bus.P0_Ack}, 32'd0);
      checkOutput({tag, "_p1_ack"}, {31'd0, bus.P1_Ack}, 32'd0);
      checkOutput({tag, "_p0_rvalid"}, {31'd0, bus.P0_Rvalid}, 32'd0);
      checkOutput({tag, "_p1_rvalid"}, {31'd0, bus.P1_Rvalid}, 32'd0);
      checkOutput({tag, "_we"}, {31'd0, bus.Mem_Write_Enable}, 32'd0);
      checkOutput({tag, "_re"}, {31'd0, bus.Mem_Read_Enable}, 32'd0);
      checkOutput({tag, "_addr"}, {24'd0, bus.Mem_Address}, 32'd0);
      checkOutput({tag, "_wdata"}, {16'd0, bus.Mem_Wdata}, 32'd0);
      checkOutput({tag, "_state_idle"}, {31'd0, dut.state_q == ARB_IDLE}, 32'd1);
   endtask

   initial begin
      int lat;
      int edges;
      logic p1_seen;
      checks = 0;
      failures = 0;
      prev_p0_ack = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      bus.P0_Req = 0; bus.P0_Write = 0; bus.P0_Address = '0; bus.P0_Wdata = '0;
      bus.P1_Req = 0; bus.P1_Write = 0; bus.P1_Address = '0; bus.P1_Wdata = '0;
      Reset_n = 1'b0;
      #2;
      checkAllZero("reset");
      step();
      Reset_n = 1'b1;
      step();

      $display("[TB] P0 write then read of address 3");
      applyStimulus(0, 1'b1, 8'd3, 16'hA5A5);
      ack_q.push_back(0);
      step();
      bus.P0_Req = 0;
      applyStimulus(0, 1'b0, 8'd3, 16'h0000);
      ack_q.push_back(0);
      pushRead(0, 16'hA5A5);
      step();
      step();
      bus.P0_Req = 0;
      repeat (4) step();

      $display("[TB] P1 write address 7 then P0 read address 7 next cycle");
      applyStimulus(1, 1'b1, 8'd7, 16'h1234);
      ack_q.push_back(1);
      step();
      bus.P1_Req = 0;
      applyStimulus(0, 1'b0, 8'd7, 16'h0000);
      ack_q.push_back(0);
      pushRead(0, 16'h1234);
      step();
      bus.P0_Req = 0;
      repeat (4) step();

      $display("[TB] both ports read, held for 6 edges");
      resetPulse();
      applyStimulus(0, 1'b0, 8'd3, 16'h0000);
      applyStimulus(1, 1'b0, 8'd7, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         ack_q.push_back(0);
         ack_q.push_back(1);
         pushRead(0, 16'hA5A5);
         pushRead(1, 16'h1234);
      end
      repeat (6) step();
      bus.P0_Req = 0;
      bus.P1_Req = 0;
      repeat (4) step();

      $display("[TB] P0 held permanently, P1 requests");
      resetPulse();
`ifdef DM_ARB_RR_EN
      ack_q.push_back(0); ack_q.push_back(1); ack_q.push_back(0); ack_q.push_back(0);
      pushRead(0, 16'hA5A5); pushRead(1, 16'h1234); pushRead(0, 16'hA5A5); pushRead(0, 16'hA5A5);
`else
      ack_q.push_back(0); ack_q.push_back(0); ack_q.push_back(1); ack_q.push_back(0);
      pushRead(0, 16'hA5A5); pushRead(0, 16'hA5A5); pushRead(1, 16'h1234); pushRead(0, 16'hA5A5);
`endif
      applyStimulus(0, 1'b0, 8'd3, 16'h0000);
      step();
      step();
      applyStimulus(1, 1'b0, 8'd7, 16'h0000);
      lat = 0;
      p1_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         lat++;
         if (bus.P1_Ack) begin
            p1_seen = 1'b1;
            break;
         end
      end
      bus.P1_Req = 0;
      checkOutput("p1_ack_within_2", {31'd0, p1_seen && (lat <= 2)}, 32'd1);
      edges = 2 + lat;
      while (edges < 6) begin
         step();
         edges++;
      end
      bus.P0_Req = 0;
      repeat (4) step();

      $display("[TB] reset asserted during a read Ack cycle");
      applyStimulus(0, 1'b0, 8'd3, 16'h0000);
      step();
      Reset_n = 1'b0;
      bus.P0_Req = 0;
      #1;
      checkAllZero("midreset");
      step();
      step();
      Reset_n = 1'b1;
      repeat (4) step();

      $display("[TB] 10 idle cycles");
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         checkOutput("idle_we", {31'd0, bus.Mem_Write_Enable}, 32'd0);
         checkOutput("idle_re", {31'd0, bus.Mem_Read_Enable}, 32'd0);
      end

      checkOutput("ack_queue_drained", ack_q.size(), 32'd0);
      checkOutput("read_queue_drained", rd_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
